serial_addsub_datapath: RTL

- Bit-serial adder/subtractor datapath. It consumes the reset/load/enable strobes produced by the serial add/sub control FSM.
- Captures two WIDTH-bit operands on load, then processes one bit per enabled cycle, LSB first, through a single full adder and a carry flip-flop.
- After WIDTH enabled cycles it presents the full result, carry-out and signed overflow, and raises done.

---
 rtl/serial_addsub_datapath.sv | 121 ++++++++++++
 1 files changed

// File: rtl/serial_addsub_datapath.sv
// Bit-serial add/subtract: one bit per enabled cycle, LSB first; done after WIDTH enables.
// No backpressure: enable gaps simply stretch the operation, and results hold until the next load.
module serial_addsub_datapath #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             reset,
   input  logic             load,
   input  logic             enable,
   input  logic             sub,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             done
);

   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             sub_q, sub_d;
   logic             c_msb_q, c_msb_d;
   logic             carry_out_q, carry_out_d;
   logic             overflow_q, overflow_d;
   logic             done_q, done_d;

   logic b_eff, s_bit, c_next;

   // Single full adder; subtract inverts B and uses carry-in of 1 (loaded at load time).
   always_comb begin
      b_eff  = b_sr_q[0] ^ sub_q;
      s_bit  = a_sr_q[0] ^ b_eff ^ carry_q;
      c_next = (a_sr_q[0] & b_eff) | (a_sr_q[0] & carry_q) | (b_eff & carry_q);
   end

   always_comb begin
      a_sr_d      = a_sr_q;
      b_sr_d      = b_sr_q;
      result_d    = result_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      sub_d       = sub_q;
      c_msb_d     = c_msb_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;
      done_d      = done_q;
      if (reset) begin
         a_sr_d      = '0;
         b_sr_d      = '0;
         result_d    = '0;
         cnt_d       = '0;
         carry_d     = 1'b0;
         sub_d       = 1'b0;
         c_msb_d     = 1'b0;
         carry_out_d = 1'b0;
         overflow_d  = 1'b0;
         done_d      = 1'b0;
      end else if (load) begin
         a_sr_d      = a_in;
         b_sr_d      = b_in;
         sub_d       = sub;
         carry_d     = sub;
         result_d    = '0;
         cnt_d       = '0;
         done_d      = 1'b0;
         carry_out_d = 1'b0;
         overflow_d  = 1'b0;
      end else if (enable && !done_q) begin
         result_d = {s_bit, result_q[WIDTH-1:1]};
         a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
         b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
         carry_d  = c_next;
         cnt_d    = cnt_q + 1'b1;
         if (cnt_q == CNT_W'(WIDTH - 2))
            c_msb_d = c_next;
         // Signed overflow: carry into the MSB differs from carry out of it.
         if (cnt_q == CNT_W'(WIDTH - 1)) begin
            carry_out_d = c_next;
            overflow_d  = c_next ^ c_msb_q;
            done_d      = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         a_sr_q      <= '0;
         b_sr_q      <= '0;
         result_q    <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         sub_q       <= 1'b0;
         c_msb_q     <= 1'b0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         a_sr_q      <= a_sr_d;
         b_sr_q      <= b_sr_d;
         result_q    <= result_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         sub_q       <= sub_d;
         c_msb_q     <= c_msb_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
         done_q      <= done_d;
      end
   end

   assign result    = result_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;
   assign done      = done_q;

endmodule
